// File: rtl/result_digit_formatter_if.sv
// Handshake and display bus for result_digit_formatter.
// Master drives start/value/err; slave returns chars/digit_en/busy/done.
interface result_digit_formatter_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_DIGITS = 4
);
  logic                    start;
  logic [WIDTH-1:0]        value;
  logic                    err;
  logic [5*NUM_DIGITS-1:0] chars;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    busy;
  logic                    done;

  modport master (
    output start, value, err,
    input  chars, digit_en, busy, done
  );

  modport slave (
    input  start, value, err,
    output chars, digit_en, busy, done
  );
endinterface

// File: rtl/result_digit_formatter.sv
// Signed result to 7-seg character codes via serial shift-add-3.
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module result_digit_formatter #(
  parameter int WIDTH      = 8,
  parameter int NUM_DIGITS = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  result_digit_formatter_if.slave bus
);

  localparam int BCD_DIGITS = (WIDTH * 30103 + 99999) / 100000 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int EXT_D      = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS
                                                        : BCD_DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);

  localparam logic [4:0] C_F     = 5'd10;
  localparam logic [4:0] C_MINUS = 5'd11;
  localparam logic [4:0] C_R     = 5'd13;
  localparam logic [4:0] C_E     = 5'd14;
  localparam logic [4:0] C_BLANK = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FORMAT
  } state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        mag_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sign_q;
  logic                    err_q;
  logic [5*NUM_DIGITS-1:0] chars_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    busy_q;
  logic                    done_q;

  logic [WIDTH-1:0]        abs_val;
  logic [WIDTH-1:0]        mag_d;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_d;
  logic [4*EXT_D-1:0]      bcd_ext;
  logic                    ovf;
  logic [5*NUM_DIGITS-1:0] chars_d;
  logic [NUM_DIGITS-1:0]   en_d;

  // Unsigned magnitude; most-negative input wraps to 2^(WIDTH-1).
  always_comb begin
    abs_val = bus.value;
    if (bus.value[WIDTH-1]) begin
      abs_val = ~bus.value + WIDTH'(1);
    end
  end

  // One double-dabble step: correct nibbles >= 5, then shift in a bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = (bcd_adj << 1)
          | {{(BCD_W-1){1'b0}}, mag_q[WIDTH-1]};
    mag_d = mag_q << 1;
  end

  // Zero-extend so every display digit has a nibble to read.
  assign bcd_ext = (4*EXT_D)'(bcd_q);

  // Display pattern from the finished BCD value: err, overflow, normal.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    int msd;
    msd = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) begin
        msd = i;
      end
    end
`endif
    ovf = 1'b0;
    for (int i = NUM_DIGITS; i < EXT_D; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) begin
        ovf = 1'b1;
      end
    end
    if (sign_q && bcd_ext[4*(NUM_DIGITS-1) +: 4] != 4'd0) begin
      ovf = 1'b1;
    end

    en_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      chars_d[5*i +: 5] = C_BLANK;
    end

    if (err_q) begin
      chars_d[5*(NUM_DIGITS-1) +: 5] = C_E;
      chars_d[5*(NUM_DIGITS-2) +: 5] = C_R;
      chars_d[5*(NUM_DIGITS-3) +: 5] = C_R;
      en_d[NUM_DIGITS-1]             = 1'b1;
      en_d[NUM_DIGITS-2]             = 1'b1;
      en_d[NUM_DIGITS-3]             = 1'b1;
    end else if (ovf) begin
      chars_d[4:0] = C_F;
      en_d[0]      = 1'b1;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (i <= msd) begin
          chars_d[5*i +: 5] = {1'b0, bcd_ext[4*i +: 4]};
          en_d[i]           = 1'b1;
        end else if (sign_q && i == msd + 1) begin
          chars_d[5*i +: 5] = C_MINUS;
          en_d[i]           = 1'b1;
        end
      end
`else
      for (int i = 0; i < NUM_DIGITS; i++) begin
        chars_d[5*i +: 5] = {1'b0, bcd_ext[4*i +: 4]};
      end
      en_d = '1;
      if (sign_q) begin
        chars_d[5*(NUM_DIGITS-1) +: 5] = C_MINUS;
      end
`endif
    end
  end

  // Control FSM: capture, WIDTH shift cycles, then register outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      chars_q <= {NUM_DIGITS{C_BLANK}};
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            err_q   <= bus.err;
            sign_q  <= bus.value[WIDTH-1];
            mag_q   <= abs_val;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_FORMAT;
          end
        end
        S_FORMAT: begin
          chars_q <= chars_d;
          en_q    <= en_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.chars    = chars_q;
  assign bus.digit_en = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
